// File: rtl/axi_lite_ram_ctrl_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the RAM controller (slave).
interface axi_lite_ram_ctrl_if #(
  parameter int unsigned AXI_ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH_BYTES = 4
) ();
  localparam int unsigned DataWidthBits = DATA_WIDTH_BYTES * 8;

  logic                        awvalid;
  logic                        awready;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        wvalid;
  logic                        wready;
  logic [DataWidthBits-1:0]    wdata;
  logic [DATA_WIDTH_BYTES-1:0] wstrb;
  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        rvalid;
  logic                        rready;
  logic [DataWidthBits-1:0]    rdata;
  logic [1:0]                  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave in front of a single-cycle RAM. Writes are done as read-modify-write so that
// WSTRB is honoured even though the RAM zeroes unstrobed bytes. The write merge and the AXI read
// share the RAM read port through an alternating-priority arbiter.
module axi_lite_ram_ctrl #(
  parameter  int unsigned NUM_SLOTS        = 6,
  parameter  int unsigned DATA_WIDTH_BYTES = 4,
  parameter  int unsigned AXI_ADDR_WIDTH   = 8,
  localparam int unsigned ADDR_WIDTH_BITS  = $clog2(NUM_SLOTS),
  localparam int unsigned DATA_WIDTH_BITS  = DATA_WIDTH_BYTES * 8
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_lite_ram_ctrl_if.slave          axi,
  output logic                        ram_r_en,
  output logic [ADDR_WIDTH_BITS-1:0]  ram_r_addr,
  input  logic [DATA_WIDTH_BITS-1:0]  ram_r_data,
  output logic                        ram_w_en,
  output logic [ADDR_WIDTH_BITS-1:0]  ram_w_addr,
  output logic [DATA_WIDTH_BITS-1:0]  ram_w_data,
  output logic [DATA_WIDTH_BYTES-1:0] ram_w_strb
);

  localparam int unsigned OffsetBits = $clog2(DATA_WIDTH_BYTES);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  // last_winner encoding; reset to WinRead so the write side wins the first contention.
  localparam logic        WinWrite   = 1'b0;
  localparam logic        WinRead    = 1'b1;

  typedef enum logic [1:0] {WrIdle, WrMerge, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdFetch, RdResp} rd_state_e;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr >> OffsetBits) < AXI_ADDR_WIDTH'(NUM_SLOTS);
  endfunction

  function automatic logic [ADDR_WIDTH_BITS-1:0] slot_of(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return ADDR_WIDTH_BITS'(addr >> OffsetBits);
  endfunction

  wr_state_e                   wr_state_q, wr_state_d;
  logic                        aw_held_q, aw_held_d;
  logic                        w_held_q, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH_BITS-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH_BYTES-1:0] wstrb_q, wstrb_d;
  logic [1:0]                  bresp_q, bresp_d;

  rd_state_e                   rd_state_q, rd_state_d;
  logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH_BITS-1:0]  rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        last_winner_q, last_winner_d;
  logic                        wr_req, rd_req;
  logic                        grant_wr, grant_rd;

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WrIdle;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  // Write FSM next state and holding-register updates; AW and W are captured independently.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (axi.awvalid && !aw_held_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = axi.awaddr;
        end
        if (axi.wvalid && !w_held_q) begin
          w_held_d = 1'b1;
          wdata_d  = axi.wdata;
          wstrb_d  = axi.wstrb;
        end
        // Decide on the incoming values so a same-cycle AW+W merges in the very next cycle.
        if (aw_held_d && w_held_d) begin
          if (in_range(awaddr_d)) begin
            wr_state_d = WrMerge;
            bresp_d    = RespOkay;
          end else begin
            wr_state_d = WrResp;
            bresp_d    = RespSlvErr;
          end
        end
      end
      WrMerge: begin
        if (grant_wr) begin
          wr_state_d = WrResp;
        end
      end
      WrResp: begin
        if (axi.bready) begin
          wr_state_d = WrIdle;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Write FSM outputs: channel readies, response valid and arbiter request.
  always_comb begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    wr_req      = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        axi.awready = ~aw_held_q;
        axi.wready  = ~w_held_q;
      end
      WrMerge: wr_req     = 1'b1;
      WrResp:  axi.bvalid = 1'b1;
      default: ;
    endcase
  end

  assign axi.bresp = bresp_q;

  // Write holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RespOkay;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RdIdle;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // Read FSM next state; out-of-range reads skip the RAM and answer SLVERR with zero data.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (axi.arvalid) begin
          araddr_d = axi.araddr;
          if (in_range(axi.araddr)) begin
            rd_state_d = RdFetch;
          end else begin
            rd_state_d = RdResp;
            rdata_d    = '0;
            rresp_d    = RespSlvErr;
          end
        end
      end
      RdFetch: begin
        if (grant_rd) begin
          rd_state_d = RdResp;
          rdata_d    = ram_r_data;
          rresp_d    = RespOkay;
        end
      end
      RdResp: begin
        if (axi.rready) begin
          rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Read FSM outputs: address ready, response valid and arbiter request.
  always_comb begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    rd_req      = 1'b0;
    unique case (rd_state_q)
      RdIdle:  axi.arready = 1'b1;
      RdFetch: rd_req      = 1'b1;
      RdResp:  axi.rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign axi.rdata = rdata_q;
  assign axi.rresp = rresp_q;

  // Read capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // RAM read-port arbiter and RAM port drive
  // ---------------------------------------------------------------------------------------------

  // Lone requests win immediately; on contention the previous loser wins.
  always_comb begin
    grant_wr      = 1'b0;
    grant_rd      = 1'b0;
    last_winner_d = last_winner_q;
    if (wr_req && rd_req) begin
      if (last_winner_q == WinRead) begin
        grant_wr      = 1'b1;
        last_winner_d = WinWrite;
      end else begin
        grant_rd      = 1'b1;
        last_winner_d = WinRead;
      end
    end else begin
      grant_wr = wr_req;
      grant_rd = rd_req;
    end
  end

  // Arbiter history, updated only on contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_q <= WinRead;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

  // RAM port: a write grant reads and rewrites the full word with strobed bytes replaced.
  always_comb begin
    ram_r_en   = 1'b0;
    ram_r_addr = '0;
    ram_w_en   = 1'b0;
    ram_w_addr = '0;
    ram_w_data = '0;
    ram_w_strb = '0;
    if (grant_wr) begin
      ram_r_en   = 1'b1;
      ram_r_addr = slot_of(awaddr_q);
      ram_w_en   = 1'b1;
      ram_w_addr = slot_of(awaddr_q);
      ram_w_strb = '1;
      for (int i = 0; i < int'(DATA_WIDTH_BYTES); i++) begin
        ram_w_data[i*8 +: 8] = wstrb_q[i] ? wdata_q[i*8 +: 8] : ram_r_data[i*8 +: 8];
      end
    end else if (grant_rd) begin
      ram_r_en   = 1'b1;
      ram_r_addr = slot_of(araddr_q);
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// Bench for axi_lite_ram_ctrl: a vector table of single transactions plus directed sequences
// for split AW/W, response back-pressure, read/write contention and reset during a merge.
module tb_axi_lite_ram_ctrl;
  localparam int unsigned NumSlots = 6;
  localparam int unsigned Bytes    = 4;
  localparam int unsigned AddrW    = 8;
  localparam int unsigned SlotW    = 3;
  localparam int unsigned DataW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_ram_ctrl_if #(.AXI_ADDR_WIDTH(AddrW), .DATA_WIDTH_BYTES(Bytes)) axi ();

  logic             ram_r_en;
  logic [SlotW-1:0] ram_r_addr;
  logic [DataW-1:0] ram_r_data;
  logic             ram_w_en;
  logic [SlotW-1:0] ram_w_addr;
  logic [DataW-1:0] ram_w_data;
  logic [Bytes-1:0] ram_w_strb;

  axi_lite_ram_ctrl #(
    .NUM_SLOTS       (NumSlots),
    .DATA_WIDTH_BYTES(Bytes),
    .AXI_ADDR_WIDTH  (AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .ram_r_en  (ram_r_en),
    .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data),
    .ram_w_en  (ram_w_en),
    .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data),
    .ram_w_strb(ram_w_strb)
  );

  // RAM model: combinational read, clocked write that zeroes unstrobed bytes.
  logic [DataW-1:0] mem [NumSlots];
  assign ram_r_data = (int'(ram_r_addr) < NumSlots) ? mem[ram_r_addr] : '0;
  always @(posedge clk) begin
    if (ram_w_en && int'(ram_w_addr) < NumSlots) begin
      for (int i = 0; i < int'(Bytes); i++) begin
        mem[ram_w_addr][i*8 +: 8] <= ram_w_strb[i] ? ram_w_data[i*8 +: 8] : 8'h00;
      end
    end
  end

  // RAM port activity counters.
  int wcnt = 0;
  int rcnt = 0;
  always @(negedge clk) begin
    if (ram_w_en) wcnt++;
    if (ram_r_en) rcnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " awready"}, 32'(axi.awready), 32'd1);
    chk({tag, " wready"},  32'(axi.wready),  32'd1);
    chk({tag, " arready"}, 32'(axi.arready), 32'd1);
    chk({tag, " bvalid"},  32'(axi.bvalid),  32'd0);
    chk({tag, " rvalid"},  32'(axi.rvalid),  32'd0);
    chk({tag, " bresp"},   32'(axi.bresp),   32'd0);
    chk({tag, " rresp"},   32'(axi.rresp),   32'd0);
    chk({tag, " rdata"},   axi.rdata,        32'd0);
    chk({tag, " ram_r_en"}, 32'(ram_r_en),   32'd0);
    chk({tag, " ram_r_addr"}, 32'(ram_r_addr), 32'd0);
    chk({tag, " ram_w_en"}, 32'(ram_w_en),   32'd0);
    chk({tag, " ram_w_addr"}, 32'(ram_w_addr), 32'd0);
    chk({tag, " ram_w_data"}, ram_w_data,    32'd0);
    chk({tag, " ram_w_strb"}, 32'(ram_w_strb), 32'd0);
  endtask

  // One AXI write; lat counts clock edges from the AW/W handshake to the first bvalid cycle.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    axi.awvalid = 1'b1;
    axi.awaddr  = addr;
    axi.wvalid  = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = strb;
    n = 0;
    while (!(axi.awready && axi.wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    lat = 1;
    while (!axi.bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    resp = axi.bresp;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  // One AXI read; lat counts clock edges from the AR handshake to the first rvalid cycle.
  task automatic axi_read(input logic [7:0] addr, output logic [1:0] resp,
                          output logic [31:0] data, output int lat);
    int n;
    @(negedge clk);
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    n = 0;
    while (!axi.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    lat = 1;
    while (!axi.rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    resp = axi.rresp;
    data = axi.rdata;
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  localparam int NumVecs = 15;
  vec_t vecs [NumVecs];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] rd;
    int          lat, lat2, w0, r0;

    vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        2};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b1, 8'h04, 32'h00001234, 4'h3, 2'b00, 32'h0,        2};
    vecs[3]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEAD1234, 2};
    vecs[4]  = '{1'b1, 8'h05, 32'hAB000000, 4'h8, 2'b00, 32'h0,        2};
    vecs[5]  = '{1'b0, 8'h07, 32'h0,        4'h0, 2'b00, 32'hABAD1234, 2};
    vecs[6]  = '{1'b1, 8'h08, 32'h55667788, 4'hF, 2'b00, 32'h0,        2};
    vecs[7]  = '{1'b1, 8'h0A, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        2};
    vecs[8]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h55667788, 2};
    vecs[9]  = '{1'b1, 8'h14, 32'h0A0B0C0D, 4'h6, 2'b00, 32'h0,        2};
    vecs[10] = '{1'b0, 8'h14, 32'h0,        4'h0, 2'b00, 32'h000B0C00, 2};
    vecs[11] = '{1'b1, 8'h18, 32'hAAAAAAAA, 4'hF, 2'b10, 32'h0,        1};
    vecs[12] = '{1'b0, 8'h18, 32'h0,        4'h0, 2'b10, 32'h0,        1};
    vecs[13] = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0,        1};
    vecs[14] = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h0,        2};

    for (int i = 0; i < int'(NumSlots); i++) mem[i] = '0;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready  = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Vector table: one transaction each, sequential, no contention.
    for (int i = 0; i < NumVecs; i++) begin
      w0 = wcnt;
      r0 = rcnt;
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
      end else begin
        axi_read(vecs[i].addr, resp, rd, lat);
        chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      end
      chk($sformatf("vec%0d resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d ram_w_en count", i), 32'(wcnt - w0),
          (vecs[i].is_wr && vecs[i].exp_resp == 2'b00) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d ram_r_en count", i), 32'(rcnt - r0),
          (vecs[i].exp_resp == 2'b00) ? 32'd1 : 32'd0);
    end

    // First contention after reset: write wins, read sees the new data one cycle late.
    fork
      axi_write(8'h08, 32'h11111111, 4'hF, resp, lat);
      axi_read(8'h08, resp2, rd, lat2);
    join
    chk("cont1 wlat", 32'(lat), 32'd2);
    chk("cont1 rlat", 32'(lat2), 32'd3);
    chk("cont1 rdata", rd, 32'h11111111);
    chk("cont1 resp", 32'({resp, resp2}), 32'd0);

    // Second contention: read wins and returns the pre-write data.
    fork
      axi_write(8'h08, 32'h22222222, 4'hF, resp, lat);
      axi_read(8'h08, resp2, rd, lat2);
    join
    chk("cont2 wlat", 32'(lat), 32'd3);
    chk("cont2 rlat", 32'(lat2), 32'd2);
    chk("cont2 rdata", rd, 32'h11111111);
    axi_read(8'h08, resp2, rd, lat2);
    chk("cont2 readback", rd, 32'h22222222);

    // W three cycles ahead of AW, then bready held low for four cycles.
    @(negedge clk);
    axi.wvalid = 1'b1;
    axi.wdata  = 32'hCAFEF00D;
    axi.wstrb  = 4'hF;
    @(negedge clk);
    axi.wvalid = 1'b0;
    chk("split wready held", 32'(axi.wready), 32'd0);
    chk("split awready", 32'(axi.awready), 32'd1);
    w0 = wcnt;
    repeat (2) @(negedge clk);
    chk("split no early write", 32'(wcnt - w0), 32'd0);
    chk("split no early bvalid", 32'(axi.bvalid), 32'd0);
    axi.awvalid = 1'b1;
    axi.awaddr  = 8'h0C;
    @(negedge clk);
    axi.awvalid = 1'b0;
    chk("split merge w_en", 32'(ram_w_en), 32'd1);
    chk("split merge w_addr", 32'(ram_w_addr), 32'd3);
    chk("split merge w_strb", 32'(ram_w_strb), 32'hF);
    chk("split merge w_data", ram_w_data, 32'hCAFEF00D);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d bvalid", k), 32'(axi.bvalid), 32'd1);
      chk($sformatf("stall%0d bresp", k), 32'(axi.bresp), 32'd0);
      @(negedge clk);
    end
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    chk("split bvalid dropped", 32'(axi.bvalid), 32'd0);
    chk("split single write", 32'(wcnt - w0), 32'd1);
    axi_read(8'h0C, resp2, rd, lat2);
    chk("split readback", rd, 32'hCAFEF00D);

    // Third contention (write wins) leaves the write side as last winner.
    fork
      axi_write(8'h10, 32'h33333333, 4'hF, resp, lat);
      axi_read(8'h10, resp2, rd, lat2);
    join
    chk("cont3 rdata", rd, 32'h33333333);

    // Fourth contention: read is granted, write waits in merge; reset hits in that cycle.
    @(negedge clk);
    axi.awvalid = 1'b1; axi.awaddr = 8'h10; axi.wvalid = 1'b1;
    axi.wdata   = 32'h44444444; axi.wstrb = 4'hF;
    axi.arvalid = 1'b1; axi.araddr = 8'h10;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("rst pre r_en", 32'(ram_r_en), 32'd1);
    chk("rst pre w_en", 32'(ram_w_en), 32'd0);
    w0 = wcnt;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    chk("midrst no write", 32'(wcnt - w0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst no bvalid", 32'(axi.bvalid), 32'd0);
    chk("midrst no rvalid", 32'(axi.rvalid), 32'd0);
    axi_read(8'h10, resp2, rd, lat2);
    chk("postrst old data", rd, 32'h33333333);
    chk("postrst rlat", 32'(lat2), 32'd2);
    axi_write(8'h10, 32'h55555555, 4'hF, resp, lat);
    chk("postrst wlat", 32'(lat), 32'd2);
    chk("postrst wresp", 32'(resp), 32'd0);
    axi_read(8'h10, resp2, rd, lat2);
    chk("postrst readback", rd, 32'h55555555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
